// File: rtl/pi.sv
// -----------------------------------------------------------------------------
// pi -- propagate/generate unit with a registered carry-lookahead adder
//
// P and G are the bitwise propagate (A ^ B) and generate (A & B) terms and are
// purely combinational. The same terms feed a two-level carry-lookahead tree.
// The first level is made of 4-bit blocks. The second level combines the
// block propagate/generate pairs. The sum and carry-out are registered.
//
// Optional feature macro: PI_GROUP_PG_EN
//   When defined, the unit also registers two group outputs:
//     PG_q -- the AND of all P bits.
//     GG_q -- the carry-out of the lookahead tree with the carry-in forced to 0.
//   When undefined, these ports and their logic do not exist.
//
// Parameters:
//   WIDTH  operand width in bits, 1..64
//
// Ports:
//   clk     rising-edge clock for all registers
//   rst_n   asynchronous active-low reset; clears every registered output
//   A, B    operands
//   Cin     carry-in for the adder
//   P, G    combinational bitwise propagate / generate
//   S_q     registered sum (A + B + Cin) mod 2^WIDTH, 1-cycle latency
//   Cout_q  registered carry-out of A + B + Cin
//   PG_q    registered group propagate (PI_GROUP_PG_EN only)
//   GG_q    registered group generate  (PI_GROUP_PG_EN only)
// -----------------------------------------------------------------------------
module pi #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] G,
    output logic [WIDTH-1:0] S_q,
    output logic             Cout_q
`ifdef PI_GROUP_PG_EN
    ,
    output logic             PG_q,
    output logic             GG_q
`endif
);

    // Number of 4-bit lookahead blocks and the padded operand width.
    localparam int NB = (WIDTH + 3) / 4;
    localparam int PW = NB * 4;

    // Builds the full carry vector c[PW:0] from padded p/g terms.
    // Every carry is written as an explicit sum of products rather than as a
    // recurrence, so no ripple path forms inside a block or between blocks.
    function automatic logic [PW:0] cla_carries(
        input logic [PW-1:0] p,
        input logic [PW-1:0] g,
        input logic          cin
    );
        logic [NB-1:0] bp;
        logic [NB-1:0] bg;
        logic [NB:0]   bc;
        logic [PW:0]   c;
        logic          term;
        bp   = '0;
        bg   = '0;
        bc   = '0;
        c    = '0;
        term = 1'b0;

        // First level: block propagate and block generate for each nibble.
        for (int j = 0; j < NB; j++) begin
            bp[j] = &p[4*j +: 4];
            for (int k = 0; k < 4; k++) begin
                term = g[4*j+k];
                for (int m = k + 1; m < 4; m++) term = term & p[4*j+m];
                bg[j] = bg[j] | term;
            end
        end

        // Second level: the carry into each block comes straight from the block
        // terms and Cin.
        bc[0] = cin;
        for (int j = 0; j < NB; j++) begin
            term = cin;
            for (int m = 0; m <= j; m++) term = term & bp[m];
            bc[j+1] = term;
            for (int k = 0; k <= j; k++) begin
                term = bg[k];
                for (int m = k + 1; m <= j; m++) term = term & bp[m];
                bc[j+1] = bc[j+1] | term;
            end
        end

        // Carries inside each block, computed from that block's carry-in.
        for (int j = 0; j < NB; j++) begin
            for (int i = 0; i < 4; i++) begin
                term = bc[j];
                for (int m = 0; m < i; m++) term = term & p[4*j+m];
                c[4*j+i] = term;
                for (int k = 0; k < i; k++) begin
                    term = g[4*j+k];
                    for (int m = k + 1; m < i; m++) term = term & p[4*j+m];
                    c[4*j+i] = c[4*j+i] | term;
                end
            end
        end
        c[PW] = bc[NB];
        return c;
    endfunction

    logic [PW-1:0] p_pad;
    logic [PW-1:0] g_pad;
    logic [PW:0]   carry;
    logic          carry_unused;

    // Bitwise propagate/generate have no register in their path and are not
    // affected by reset.
    assign P = A ^ B;
    assign G = A & B;

    // Pad the top block with P=0, G=0.
    // The carry-out is taken at bit WIDTH, not at the top of the padded block.
    // With P=0 and G=0 in the pad bits, a carry cannot pass through them.
    always_comb begin
        p_pad = '0;
        g_pad = '0;
        p_pad[WIDTH-1:0] = P;
        g_pad[WIDTH-1:0] = G;
    end

    assign carry        = cla_carries(p_pad, g_pad, Cin);
    assign carry_unused = ^carry;

    // Sum and carry-out register. Reset clears them at once, without waiting
    // for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q    <= '0;
            Cout_q <= 1'b0;
        end else begin
            S_q    <= P ^ carry[WIDTH-1:0];
            Cout_q <= carry[WIDTH];
        end
    end

`ifdef PI_GROUP_PG_EN
    logic [PW:0] carry_zero;
    logic        carry_zero_unused;

    // Group generate is the tree's carry-out with no carry-in.
    assign carry_zero        = cla_carries(p_pad, g_pad, 1'b0);
    assign carry_zero_unused = ^carry_zero;

    // Group propagate/generate registers. They share the sum's latency and reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PG_q <= 1'b0;
            GG_q <= 1'b0;
        end else begin
            PG_q <= &P;
            GG_q <= carry_zero[WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_pi.sv
// -----------------------------------------------------------------------------
// tb_pi -- self-checking bench for pi at WIDTH = 1, 7, 16 and 32
//
// Four instances of the design share one clock and one reset. The 32-bit
// instance is driven from a table of vectors and then from random vectors.
// Its expected results go through a scoreboard queue. The narrow instances
// are checked with short hand-written sequences.
// -----------------------------------------------------------------------------
module tb_pi;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n  = 1'b1;

    logic [0:0]  a1 = '0, b1 = '0, p1, g1, s1;
    logic        cin1 = 1'b0, co1;
    logic [6:0]  a7 = '0, b7 = '0, p7, g7, s7;
    logic        cin7 = 1'b0, co7;
    logic [15:0] a16 = '0, b16 = '0, p16, g16, s16;
    logic        cin16 = 1'b0, co16;
    logic [31:0] a32 = '0, b32 = '0, p32, g32, s32;
    logic        cin32 = 1'b0, co32;
`ifdef PI_GROUP_PG_EN
    logic pg1, gg1, pg7, gg7, pg16, gg16, pg32, gg32;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        cout;
    } vec_t;

    typedef struct {
        string       name;
        logic [32:0] sum;
        logic        pg;
        logic        gg;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    pi #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1),
        .P(p1), .G(g1), .S_q(s1), .Cout_q(co1)
`ifdef PI_GROUP_PG_EN
        , .PG_q(pg1), .GG_q(gg1)
`endif
    );

    pi #(.WIDTH(7)) u_w7 (
        .clk(clk), .rst_n(rst_n), .A(a7), .B(b7), .Cin(cin7),
        .P(p7), .G(g7), .S_q(s7), .Cout_q(co7)
`ifdef PI_GROUP_PG_EN
        , .PG_q(pg7), .GG_q(gg7)
`endif
    );

    pi #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(cin16),
        .P(p16), .G(g16), .S_q(s16), .Cout_q(co16)
`ifdef PI_GROUP_PG_EN
        , .PG_q(pg16), .GG_q(gg16)
`endif
    );

    pi #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .A(a32), .B(b32), .Cin(cin32),
        .P(p32), .G(g32), .S_q(s32), .Cout_q(co32)
`ifdef PI_GROUP_PG_EN
        , .PG_q(pg32), .GG_q(gg32)
`endif
    );

    // Clock runs only once enabled. The first phase checks the purely
    // combinational paths with no clock.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives the 32-bit instance at a falling edge and queues what it must
    // show after the next rising edge.
    task automatic applyStimulus(input string name, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin,
                                 input logic [32:0] exp_sum);
        exp_t e;
        @(negedge clk);
        a32   = a;
        b32   = b;
        cin32 = cin;
        e.name = name;
        e.sum  = exp_sum;
        e.pg   = &(a ^ b);
        e.gg   = ((33'(a) + 33'(b)) >> 32) != 33'd0;
        sb.push_back(e);
        #1;
        checkOutput({name, " P"}, 64'(p32), 64'(a ^ b));
        checkOutput({name, " G"}, 64'(g32), 64'(a & b));
    endtask

    task automatic popAndCheck();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: actual=empty expected=entry");
        end else begin
            e = sb.pop_front();
            checkOutput({e.name, " sum"}, 64'({co32, s32}), 64'(e.sum));
`ifdef PI_GROUP_PG_EN
            checkOutput({e.name, " PG_q"}, 64'(pg32), 64'(e.pg));
            checkOutput({e.name, " GG_q"}, 64'(gg32), 64'(e.gg));
`endif
        end
    endtask

    initial begin
        logic [1:0]  sum1;
        logic [7:0]  sum7;
        logic [16:0] sum16;
        logic [31:0] ra, rb;
        logic        rc;

        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1};
        vecs[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0};
        vecs[6] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[8] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
        vecs[9] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 1'b1};

        // Reset asserted with no clock: registered outputs must be zero.
        rst_n = 1'b0;
        #1;
        checkOutput("reset S_q w32", 64'(s32), 64'h0);
        checkOutput("reset Cout_q w32", 64'(co32), 64'h0);
        checkOutput("reset S_q w7", 64'(s7), 64'h0);
`ifdef PI_GROUP_PG_EN
        checkOutput("reset PG_q w16", 64'(pg16), 64'h0);
        checkOutput("reset GG_q w16", 64'(gg16), 64'h0);
`endif

        // WIDTH=1 combinational truth table, no clock, reset still held.
        for (int v = 0; v < 4; v++) begin
            a1 = v[1];
            b1 = v[0];
            #100;
            checkOutput($sformatf("comb P a=%0d b=%0d", a1, b1), 64'(p1), 64'(v[1] ^ v[0]));
            checkOutput($sformatf("comb G a=%0d b=%0d", a1, b1), 64'(g1), 64'(v[1] & v[0]));
        end

        rst_n  = 1'b1;
        clk_en = 1'b1;

        // WIDTH=1: every combination of A, B and Cin.
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            a1   = v[0];
            b1   = v[1];
            cin1 = v[2];
            sum1 = 2'(a1) + 2'(b1) + 2'(cin1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("w1 sum v=%0d", v), 64'({co1, s1}), 64'(sum1));
        end

        // WIDTH=7: the partially filled top block.
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            case (v)
                0:       begin a7 = 7'h55; b7 = 7'h2B; cin7 = 1'b0; sum7 = 8'h80; end
                1:       begin a7 = 7'h7F; b7 = 7'h00; cin7 = 1'b1; sum7 = 8'h80; end
                2:       begin a7 = 7'h7F; b7 = 7'h7F; cin7 = 1'b1; sum7 = 8'hFF; end
                default: begin a7 = 7'h12; b7 = 7'h34; cin7 = 1'b0; sum7 = 8'h46; end
            endcase
            @(posedge clk);
            #1;
            checkOutput($sformatf("w7 sum v=%0d", v), 64'({co7, s7}), 64'(sum7));
        end

        // WIDTH=16: a carry that crosses every block, and group outputs.
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            case (v)
                0:       begin a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1; sum16 = 17'h10000; end
                1:       begin a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b0; sum16 = 17'h10000; end
                default: begin a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; sum16 = 17'h05555; end
            endcase
            @(posedge clk);
            #1;
            checkOutput($sformatf("w16 sum v=%0d", v), 64'({co16, s16}), 64'(sum16));
`ifdef PI_GROUP_PG_EN
            checkOutput($sformatf("w16 PG_q v=%0d", v), 64'(pg16), 64'(v == 0));
            checkOutput($sformatf("w16 GG_q v=%0d", v), 64'(gg16), 64'(v == 1));
`endif
        end

        // WIDTH=32 table vectors through the scoreboard.
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                          {vecs[i].cout, vecs[i].s});
            popAndCheck();
        end

        // Reset asserted between edges while the sums are nonzero.
        applyStimulus("pre-reset", 32'h0000_1234, 32'h0000_0001, 1'b0, 33'h0_0000_1235);
        popAndCheck();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset S_q w32", 64'(s32), 64'h0);
        checkOutput("async reset Cout_q w32", 64'(co32), 64'h0);
        checkOutput("async reset S_q w16", 64'(s16), 64'h0);
        checkOutput("async reset S_q w1", 64'(s1), 64'h0);
`ifdef PI_GROUP_PG_EN
        checkOutput("async reset PG/GG all", 64'({pg1, gg1, pg7, gg7, pg16, gg16, pg32, gg32}), 64'h0);
`endif
        checkOutput("reset P w32", 64'(p32), 64'(32'h0000_1235));
        a32 = 32'hFFFF_0000;
        b32 = 32'h0F0F_0F0F;
        #1;
        checkOutput("reset P tracks A/B", 64'(p32), 64'(32'hF0F0_0F0F));
        checkOutput("reset G tracks A/B", 64'(g32), 64'(32'h0F0F_0000));
        @(posedge clk);
        #1;
        checkOutput("held reset S_q w32", 64'(s32), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post-reset", 32'h0000_0005, 32'h0000_0006, 1'b1, 33'h0_0000_000C);
        popAndCheck();

        // Random vectors at WIDTH=32.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            applyStimulus($sformatf("rand%0d", i), ra, rb, rc,
                          33'(ra) + 33'(rb) + 33'(rc));
            popAndCheck();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pi.md
PI -- requirements
Module: pi

Interface
REQ-001 Parameter WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all registers update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  WIDTH  operand A.
REQ-005 B  input  WIDTH  operand B.
REQ-006 Cin  input  1  carry-in for the registered adder path.
REQ-007 P  output  WIDTH  bitwise propagate, combinational.
REQ-008 G  output  WIDTH  bitwise generate, combinational.
REQ-009 S_q  output  WIDTH  registered sum A+B+Cin.
REQ-010 Cout_q  output  1  registered carry-out of A+B+Cin.
REQ-011 PG_q  output  1  registered group propagate (AND of all P bits); present only with PI_GROUP_PG_EN.
REQ-012 GG_q  output  1  registered group generate; present only with PI_GROUP_PG_EN.

Function
REQ-013 P SHALL equal A XOR B bitwise, purely combinational, independent of clk, rst_n and Cin.
REQ-014 G SHALL equal A AND B bitwise, purely combinational, independent of clk, rst_n and Cin.
REQ-015 P and G SHALL settle within the same delta cycle as any A/B change; no register in these paths.
REQ-016 Carries SHALL use carry-lookahead: c[i+1] = G[i] | (P[i] & c[i]), c[0] = Cin, built from 4-bit lookahead blocks with block-level P/G combined by a second lookahead level; a ripple chain across blocks is not permitted.
REQ-017 WIDTH not a multiple of 4 SHALL be handled by padding the top block with P=0, G=0; padding SHALL not affect the outputs.
REQ-018 S_q SHALL equal P XOR c[WIDTH-1:0], captured every rising clk edge; latency is 1 cycle.
REQ-019 Cout_q SHALL equal c[WIDTH] captured on the same edge as S_q.
REQ-020 Sum is modulo 2^WIDTH; overflow is signalled only by Cout_q.
REQ-021 No handshake: registered outputs reflect the inputs sampled on the most recent rising edge after reset release.

Reset
REQ-022 rst_n low SHALL immediately clear S_q, Cout_q, PG_q and GG_q to 0, regardless of clk.
REQ-023 Reset SHALL not affect P or G; they track A and B during reset.
REQ-024 The first rising edge with rst_n high SHALL capture current inputs normally; reset asserted mid-operation discards the pending result.

Configuration
REQ-025 Macro PI_GROUP_PG_EN defined: PG_q = &P and GG_q = carry-out of the lookahead tree with Cin forced to 0, both registered with 1-cycle latency and reset to 0.
REQ-026 Macro PI_GROUP_PG_EN undefined: PG_q and GG_q ports and their logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-027 WIDTH=1, A/B stepped 0/0, 0/1, 1/0, 1/1 every 100 ns, no clock -> P = 0,1,1,0 and G = 0,0,0,1.
REQ-028 WIDTH=1, clocked, rst_n=1, A=1, B=1, Cin=1 -> next edge S_q=1, Cout_q=1.
REQ-029 WIDTH=16, A=16'hFFFF, B=16'h0000, Cin=1 -> next edge S_q=16'h0000, Cout_q=1; with PI_GROUP_PG_EN, PG_q=1, GG_q=0.
REQ-030 WIDTH=7, A=7'h55, B=7'h2B, Cin=0 -> S_q=7'h00, Cout_q=1 (verifies padding of partial block).
REQ-031 Drive rst_n low between clock edges with S_q nonzero -> S_q, Cout_q, PG_q and GG_q are 0 immediately while P/G still follow A/B.
REQ-032 Randomized 1000 vectors at WIDTH=32 -> {Cout_q,S_q} equals A+B+Cin of the prior cycle.
